// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: load/store unit back end for a combinational-read data memory.
// Ports: clk, rst_n; req_* handshake in; rsp_* completion out; dmem_* memory port.
package riscv_pkg;
    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b10
    } mem_size_t;
endpackage

module lsu_dmem_master
    import riscv_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  mem_size_t   req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wr_data,
    input  logic        req_zero_extend,
    output logic        rsp_valid,
    output logic [31:0] rsp_rd_data,
    output logic        rsp_err,
    output logic        dmem_req,
    output logic        dmem_wr_en,
    output mem_size_t   dmem_data_size,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wr_data,
    output logic        dmem_zero_extend,
    input  logic [31:0] dmem_rd_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

    state_t      state;
    logic        wr_q;
    mem_size_t   size_q;
    logic [31:0] addr_q;
    logic [31:0] wr_data_q;
    logic        zext_q;
    logic [1:0]  cnt;
    logic [31:0] buf_q;

    logic        bad_size;
    logic        mis;
    logic        last;
    logic [1:0]  cnt_nxt;
    logic [31:0] buf_nxt;
    logic [31:0] split_rd;
    logic [31:0] byte_wr;

    always_comb begin
        bad_size = !(req_size inside {BYTE, HALF_WORD, WORD});
        mis      = ((req_size == HALF_WORD) && req_addr[0]) ||
                   ((req_size == WORD) && (req_addr[1:0] != 2'b00));
        last     = (size_q == HALF_WORD) ? (cnt == 2'd1) : (cnt == 2'd3);
        cnt_nxt  = cnt + 2'd1;
        // buffer as it will look once the current byte lands
        buf_nxt  = buf_q;
        buf_nxt[{cnt, 3'b000} +: 8] = dmem_rd_data[7:0];
        if (size_q == HALF_WORD) begin
            split_rd = zext_q ? {16'd0, buf_nxt[15:0]}
                              : {{16{buf_nxt[15]}}, buf_nxt[15:0]};
        end else begin
            split_rd = buf_nxt;
        end
        byte_wr  = {24'd0, wr_data_q[{cnt_nxt, 3'b000} +: 8]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            wr_q             <= 1'b0;
            size_q           <= BYTE;
            addr_q           <= 32'd0;
            wr_data_q        <= 32'd0;
            zext_q           <= 1'b0;
            cnt              <= 2'd0;
            buf_q            <= 32'd0;
            req_ready        <= 1'b1;
            rsp_valid        <= 1'b0;
            rsp_rd_data      <= 32'd0;
            rsp_err          <= 1'b0;
            dmem_req         <= 1'b0;
            dmem_wr_en       <= 1'b0;
            dmem_data_size   <= BYTE;
            dmem_addr        <= 32'd0;
            dmem_wr_data     <= 32'd0;
            dmem_zero_extend <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q      <= req_wr;
                        size_q    <= req_size;
                        addr_q    <= req_addr;
                        wr_data_q <= req_wr_data;
                        zext_q    <= req_zero_extend;
                        req_ready <= 1'b0;
                        if (bad_size || (mis && !SPLIT_MISALIGNED)) begin
                            state       <= RESP;
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_rd_data <= 32'd0;
                        end else if (mis) begin
                            state            <= SPLIT;
                            cnt              <= 2'd0;
                            buf_q            <= 32'd0;
                            dmem_req         <= 1'b1;
                            dmem_wr_en       <= req_wr;
                            dmem_data_size   <= BYTE;
                            dmem_addr        <= req_addr;
                            dmem_wr_data     <= req_wr ? {24'd0, req_wr_data[7:0]}
                                                       : 32'd0;
                            dmem_zero_extend <= 1'b1;
                        end else begin
                            state            <= ACCESS;
                            dmem_req         <= 1'b1;
                            dmem_wr_en       <= req_wr;
                            dmem_data_size   <= req_size;
                            dmem_addr        <= req_addr;
                            dmem_wr_data     <= req_wr_data;
                            dmem_zero_extend <= req_zero_extend;
                        end
                    end
                end
                ACCESS: begin
                    state            <= RESP;
                    dmem_req         <= 1'b0;
                    dmem_wr_en       <= 1'b0;
                    dmem_data_size   <= BYTE;
                    dmem_addr        <= 32'd0;
                    dmem_wr_data     <= 32'd0;
                    dmem_zero_extend <= 1'b0;
                    rsp_valid        <= 1'b1;
                    rsp_rd_data      <= wr_q ? 32'd0 : dmem_rd_data;
                end
                SPLIT: begin
                    buf_q <= buf_nxt;
                    if (last) begin
                        state            <= RESP;
                        dmem_req         <= 1'b0;
                        dmem_wr_en       <= 1'b0;
                        dmem_data_size   <= BYTE;
                        dmem_addr        <= 32'd0;
                        dmem_wr_data     <= 32'd0;
                        dmem_zero_extend <= 1'b0;
                        rsp_valid        <= 1'b1;
                        rsp_rd_data      <= wr_q ? 32'd0 : split_rd;
                    end else begin
                        cnt          <= cnt_nxt;
                        // address wraps naturally at 2^32
                        dmem_addr    <= addr_q + {30'd0, cnt_nxt};
                        dmem_wr_data <= wr_q ? byte_wr : 32'd0;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    rsp_valid   <= 1'b0;
                    rsp_err     <= 1'b0;
                    rsp_rd_data <= 32'd0;
                    req_ready   <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb_lsu_dmem_master: randomized and directed bench with a behavioural model.
// Ports: none; drives two instances (split enabled and split disabled).
module tb_lsu_dmem_master;
    import riscv_pkg::*;

    typedef struct packed {
        logic        rdy;
        logic        dreq;
        logic        dwe;
        logic [1:0]  dsz;
        logic [31:0] dad;
        logic [31:0] dwd;
        logic        dzx;
        logic        rv;
        logic [31:0] rd;
        logic        re;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_valid1;
    logic        req_wr;
    mem_size_t   req_size;
    logic [31:0] req_addr, req_wr_data;
    logic        req_zero_extend;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rd_data;
    logic        dmem_req, dmem_wr_en, dmem_zero_extend;
    mem_size_t   dmem_data_size;
    logic [31:0] dmem_addr, dmem_wr_data, dmem_rd_data;

    logic        req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rd_data1;
    logic        dmem_req1, dmem_wr_en1, dmem_zero_extend1;
    mem_size_t   dmem_data_size1;
    logic [31:0] dmem_addr1, dmem_wr_data1, dmem_rd_data1;

    int          total = 0;
    int          bad = 0;
    bit          chk_en = 1'b0;
    bit          u1_seen = 1'b0;
    logic [31:0] last_rd;
    obs_t        expq[$];

    logic [7:0]  mem  [logic [31:0]];
    logic [7:0]  rmem [logic [31:0]];

    always #5 clk = ~clk;

    lsu_dmem_master #(.SPLIT_MISALIGNED(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_size(req_size), .req_addr(req_addr),
        .req_wr_data(req_wr_data), .req_zero_extend(req_zero_extend),
        .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data), .rsp_err(rsp_err),
        .dmem_req(dmem_req), .dmem_wr_en(dmem_wr_en),
        .dmem_data_size(dmem_data_size), .dmem_addr(dmem_addr),
        .dmem_wr_data(dmem_wr_data), .dmem_zero_extend(dmem_zero_extend),
        .dmem_rd_data(dmem_rd_data)
    );

    lsu_dmem_master #(.SPLIT_MISALIGNED(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_wr(req_wr), .req_size(req_size), .req_addr(req_addr),
        .req_wr_data(req_wr_data), .req_zero_extend(req_zero_extend),
        .rsp_valid(rsp_valid1), .rsp_rd_data(rsp_rd_data1), .rsp_err(rsp_err1),
        .dmem_req(dmem_req1), .dmem_wr_en(dmem_wr_en1),
        .dmem_data_size(dmem_data_size1), .dmem_addr(dmem_addr1),
        .dmem_wr_data(dmem_wr_data1), .dmem_zero_extend(dmem_zero_extend1),
        .dmem_rd_data(dmem_rd_data1)
    );

    function automatic logic [7:0] mrd(logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] rrd(logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] env_read(logic [31:0] a, logic [1:0] sz,
                                             logic zx);
        logic [31:0] w;
        w = {mrd(a + 3), mrd(a + 2), mrd(a + 1), mrd(a)};
        if (sz == 2'd0) return zx ? {24'd0, w[7:0]} : {{24{w[7]}}, w[7:0]};
        if (sz == 2'd1) return zx ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
        return w;
    endfunction

    // data memory environment: write then combinational read, once per cycle
    always @(negedge clk) begin
        if (dmem_req && dmem_wr_en) begin
            mem[dmem_addr] = dmem_wr_data[7:0];
            if (dmem_data_size != BYTE) mem[dmem_addr + 1] = dmem_wr_data[15:8];
            if (dmem_data_size == WORD) begin
                mem[dmem_addr + 2] = dmem_wr_data[23:16];
                mem[dmem_addr + 3] = dmem_wr_data[31:24];
            end
        end
        dmem_rd_data  = env_read(dmem_addr, dmem_data_size, dmem_zero_extend);
        dmem_rd_data1 = env_read(dmem_addr1, dmem_data_size1, dmem_zero_extend1);
        if (dmem_req1) u1_seen = 1'b1;
    end

    function automatic obs_t idle_obs();
        obs_t e;
        e = '0;
        e.rdy = 1'b1;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // per-cycle comparison of u0 against the model's expected cycle queue
    always @(negedge clk) begin
        obs_t e;
        obs_t g;
        if (chk_en) begin
            if (expq.size() != 0) e = expq.pop_front();
            else e = idle_obs();
            g = '{req_ready, dmem_req, dmem_wr_en, dmem_data_size, dmem_addr,
                  dmem_wr_data, dmem_zero_extend, rsp_valid, rsp_rd_data, rsp_err};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL cycle @%0t: got %h want %h", $time, g, e);
            end
            if (g.rv) last_rd = g.rd;
        end
    end

    // behavioural model: whole transaction from the access rules
    task automatic push_model(input logic wr, input logic [1:0] sz,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic zx, output logic [31:0] exp_rd);
        obs_t        e;
        int          n;
        logic        mis;
        logic [31:0] v;
        mis = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        if (sz == 2'd3) begin
            e = '0; e.rv = 1'b1; e.re = 1'b1;
            expq.push_back(e);
            exp_rd = 32'd0;
            return;
        end
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (wr) rmem[a + i] = d[8*i +: 8];
            else v[8*i +: 8] = rrd(a + i);
        end
        if (n == 1 && !zx) v = {{24{v[7]}}, v[7:0]};
        if (n == 2 && !zx) v = {{16{v[15]}}, v[15:0]};
        if (mis) begin
            for (int i = 0; i < n; i++) begin
                e = '0; e.dreq = 1'b1; e.dwe = wr; e.dsz = 2'd0;
                e.dad = a + i; e.dzx = 1'b1;
                e.dwd = wr ? {24'd0, d[8*i +: 8]} : 32'd0;
                expq.push_back(e);
            end
        end else begin
            e = '0; e.dreq = 1'b1; e.dwe = wr; e.dsz = sz;
            e.dad = a; e.dwd = d; e.dzx = zx;
            expq.push_back(e);
        end
        e = '0; e.rv = 1'b1; e.rd = wr ? 32'd0 : v;
        expq.push_back(e);
        exp_rd = wr ? 32'd0 : v;
    endtask

    task automatic junk();
        req_valid       = 1'($urandom);
        req_wr          = 1'($urandom);
        req_size        = mem_size_t'(2'($urandom));
        req_addr        = $urandom;
        req_wr_data     = $urandom;
        req_zero_extend = 1'($urandom);
    endtask

    // call at posedge+1 while the DUT is idle
    task automatic do_req(input logic wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic zx, output logic [31:0] exp_rd);
        int k;
        last_rd         = 32'hDEADBEEF;
        req_valid       = 1'b1;
        req_wr          = wr;
        req_size        = mem_size_t'(sz);
        req_addr        = a;
        req_wr_data     = d;
        req_zero_extend = zx;
        @(posedge clk); #1;
        push_model(wr, sz, a, d, zx, exp_rd);
        k = 0;
        while (expq.size() != 0 && k < 20) begin
            junk();
            @(posedge clk); #1;
            k++;
        end
        if (expq.size() != 0) begin
            chk("timeout", 32'(expq.size()), 32'd0);
            expq.delete();
        end
        req_valid = 1'b0;
    endtask

    task automatic dir(input string nm, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic zx, input logic [31:0] lit);
        logic [31:0] er;
        do_req(wr, sz, a, d, zx, er);
        chk({nm, " model"}, er, lit);
        chk({nm, " dut"}, last_rd, lit);
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] b);
        mem[a]  = b;
        rmem[a] = b;
    endtask

    initial begin
        logic [31:0] er;
        logic [31:0] a;
        rst_n = 1'b0;
        req_valid = 1'b0; req_valid1 = 1'b0;
        req_wr = 1'b0; req_size = BYTE; req_addr = 32'd0;
        req_wr_data = 32'd0; req_zero_extend = 1'b0;
        for (int i = 0; i < 64; i++) poke(32'h100 + i, 8'($urandom));
        for (int i = 0; i < 16; i++) poke(32'hFFFFFFF0 + i, 8'($urandom));
        for (int i = 0; i < 16; i++) poke(32'(i), 8'($urandom));
        repeat (2) @(negedge clk);
        chk("reset state",
            {31'd0, req_ready} | {30'd0, dmem_req, 1'b0} | {29'd0, rsp_valid, 2'b0}
            | dmem_addr | rsp_rd_data, 32'd1);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        poke(32'h100, 8'h78); poke(32'h101, 8'h56);
        poke(32'h102, 8'h34); poke(32'h103, 8'h12);
        dir("lw 100", 1'b0, 2'd2, 32'h100, 32'd0, 1'b0, 32'h12345678);
        poke(32'h10, 8'h80);
        dir("lb 10", 1'b0, 2'd0, 32'h10, 32'd0, 1'b0, 32'hFFFFFF80);
        dir("lbu 10", 1'b0, 2'd0, 32'h10, 32'd0, 1'b1, 32'h00000080);

        // split-disabled instance
        u1_seen = 1'b0;
        req_valid1 = 1'b1; req_wr = 1'b0; req_size = HALF_WORD;
        req_addr = 32'h201; req_zero_extend = 1'b0;
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        @(negedge clk);
        chk("u1 err rsp", {30'd0, rsp_valid1, rsp_err1}, 32'd3);
        chk("u1 err data", rsp_rd_data1, 32'd0);
        @(negedge clk);
        chk("u1 back idle", {30'd0, req_ready1, rsp_valid1}, 32'd2);
        chk("u1 no dmem", {31'd0, u1_seen}, 32'd0);
        @(posedge clk); #1;
        req_valid1 = 1'b1; req_size = WORD; req_addr = 32'h100;
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        @(negedge clk);
        chk("u1 lw addr", dmem_addr1, 32'h100);
        @(negedge clk);
        chk("u1 lw data", rsp_rd_data1, 32'h12345678);
        @(posedge clk); #1;

        poke(32'h103, 8'h11); poke(32'h104, 8'h22);
        poke(32'h105, 8'h33); poke(32'h106, 8'h44);
        dir("lw 103", 1'b0, 2'd2, 32'h103, 32'd0, 1'b0, 32'h44332211);
        poke(32'h106, 8'hF4);
        dir("lh 105", 1'b0, 2'd1, 32'h105, 32'd0, 1'b0, 32'hFFFFF433);
        for (int i = 1; i < 5; i++) poke(32'(i), 8'hFF);
        dir("sw 1", 1'b1, 2'd2, 32'h1, 32'h0000A1B2, 1'b0, 32'd0);
        chk("mem 1", {24'd0, mrd(32'h1)}, 32'hB2);
        chk("mem 2", {24'd0, mrd(32'h2)}, 32'hA1);
        chk("mem 3", {24'd0, mrd(32'h3)}, 32'h00);
        chk("mem 4", {24'd0, mrd(32'h4)}, 32'h00);
        dir("lw 1", 1'b0, 2'd2, 32'h1, 32'd0, 1'b0, 32'h0000A1B2);

        // wrap-around split interrupted by reset at i=2
        req_valid = 1'b1; req_wr = 1'b0; req_size = WORD;
        req_addr = 32'hFFFFFFFE; req_zero_extend = 1'b0;
        @(posedge clk); #1;
        push_model(1'b0, 2'd2, 32'hFFFFFFFE, 32'd0, 1'b0, er);
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk("wrap i2 addr", dmem_addr, 32'h00000000);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("rst dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst req_ready", {31'd0, req_ready}, 32'd1);
        expq.delete();
        @(posedge clk); #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        dir("lw 100 again", 1'b0, 2'd2, 32'h100, 32'd0, 1'b0, 32'h11345678);

        for (int n = 0; n < 250; n++) begin
            logic [1:0] sz;
            case ($urandom_range(0, 2))
                0: a = 32'h100 + $urandom_range(0, 60);
                1: a = 32'hFFFFFFF0 + $urandom_range(0, 15);
                default: a = $urandom_range(0, 15);
            endcase
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_req(1'($urandom), sz, a, $urandom, 1'($urandom), er);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
